// File: rtl/frame_share_pkg.sv
// rtl/frame_share_pkg.sv - shared constants for the ping-pong frame share
package frame_share_pkg;

  // control write bits
  localparam int COMMIT_BIT  = 0;
  localparam int RELEASE_BIT = 0;
  localparam int IRQ_ACK_BIT = 1;

  // status read field positions
  localparam int ST_FRONT   = 0;
  localparam int ST_PENDING = 1;
  localparam int ST_IRQ     = 1;
  localparam int ST_IDLE    = 2;
  localparam int ST_CNT_LSB = 16;

  // all-ones source for saturating counters, sliced to the counter width
  localparam logic [63:0] SAT_ONES = '1;

endpackage

// File: rtl/frame_share_dpram.sv
// rtl/frame_share_dpram.sv - true dual-port RAM with registered read ports
module frame_share_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // contents are deliberately never reset so stale frames survive a reset
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
    if (b_we) mem[b_addr] <= b_din;
    a_dout <= mem[a_addr];
    b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/frame_share_pingpong.sv
// rtl/frame_share_pingpong.sv - host/client ping-pong frame buffer with commit/release swap
module frame_share_pingpong
  import frame_share_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_we,
  input  logic              host_sel_buf,
  input  logic              host_sel_ctrl,
  input  logic [31:0]       host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout,
  input  logic              client_we,
  input  logic              client_sel_buf,
  input  logic              client_sel_ctrl,
  input  logic [31:0]       client_addr,
  input  logic [DATA_W-1:0] client_din,
  output logic [DATA_W-1:0] client_dout,
  output logic              client_irq,
  output logic              front,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int STAT_W = ST_CNT_LSB + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = SAT_ONES[CNT_W-1:0];

  logic             pending;
  logic             client_idle;
  logic [CNT_W-1:0] frame_count;

  logic [ADDR_W-1:0] host_word;
  logic [ADDR_W-1:0] client_word;
  logic              unused_addr_bits;

  assign host_word        = host_addr[ADDR_W+1:2];
  assign client_word      = client_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{host_addr[31:ADDR_W+2], host_addr[1:0],
                              client_addr[31:ADDR_W+2], client_addr[1:0]};

  logic commit_req;
  logic rel_req;
  logic ack_req;
  logic swap;

  assign commit_req = host_we && host_sel_ctrl && host_din[COMMIT_BIT];
  assign rel_req    = client_we && client_sel_ctrl && client_din[RELEASE_BIT];
  assign ack_req    = client_we && client_sel_ctrl && client_din[IRQ_ACK_BIT];
  assign swap       = pending && client_idle;

  logic [DATA_W-1:0] host_ram_dout;
  logic [DATA_W-1:0] client_ram_dout;

  // bank select uses the registered front, so a swap cycle still decodes pre-swap
  frame_share_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk    (clk),
    .a_we   (host_we && host_sel_buf),
    .a_addr ({~front, host_word}),
    .a_din  (host_din),
    .a_dout (host_ram_dout),
    .b_we   (client_we && client_sel_buf),
    .b_addr ({front, client_word}),
    .b_din  (client_din),
    .b_dout (client_ram_dout)
  );

  logic [STAT_W-1:0]        host_stat;
  logic [STAT_W-1:0]        client_stat;
  logic [STAT_W+DATA_W-1:0] host_stat_wide;
  logic [STAT_W+DATA_W-1:0] client_stat_wide;

  always_comb begin
    host_stat                         = '0;
    host_stat[ST_FRONT]               = front;
    host_stat[ST_PENDING]             = pending;
    host_stat[ST_CNT_LSB +: CNT_W]    = drop_count;
    client_stat                       = '0;
    client_stat[ST_FRONT]             = front;
    client_stat[ST_IRQ]               = client_irq;
    client_stat[ST_IDLE]              = client_idle;
    client_stat[ST_CNT_LSB +: CNT_W]  = frame_count;
  end

  assign host_stat_wide   = {{DATA_W{1'b0}}, host_stat};
  assign client_stat_wide = {{DATA_W{1'b0}}, client_stat};

  always_ff @(posedge clk) begin
    if (!reset) begin
      front       <= 1'b0;
      pending     <= 1'b0;
      client_idle <= 1'b1;
      client_irq  <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (swap) begin
        front       <= ~front;
        frame_count <= frame_count + 1'b1;
      end
      // a commit landing on the swap cycle re-arms pending for the next frame
      pending <= swap ? commit_req : (pending | commit_req);
      if (commit_req && pending && !swap && drop_count != CNT_MAX)
        drop_count <= drop_count + 1'b1;
      client_idle <= rel_req | (client_idle & ~swap);
      client_irq  <= swap | (client_irq & ~ack_req);
    end
  end

  logic              host_sel_buf_q;
  logic              host_sel_ctrl_q;
  logic [DATA_W-1:0] host_ctrl_q;
  logic              client_sel_buf_q;
  logic              client_sel_ctrl_q;
  logic [DATA_W-1:0] client_ctrl_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      host_sel_buf_q    <= 1'b0;
      host_sel_ctrl_q   <= 1'b0;
      host_ctrl_q       <= '0;
      client_sel_buf_q  <= 1'b0;
      client_sel_ctrl_q <= 1'b0;
      client_ctrl_q     <= '0;
    end else begin
      host_sel_buf_q    <= host_sel_buf;
      host_sel_ctrl_q   <= host_sel_ctrl;
      host_ctrl_q       <= host_stat_wide[DATA_W-1:0];
      client_sel_buf_q  <= client_sel_buf;
      client_sel_ctrl_q <= client_sel_ctrl;
      client_ctrl_q     <= client_stat_wide[DATA_W-1:0];
    end
  end

  assign host_dout   = host_sel_buf_q    ? host_ram_dout   :
                       host_sel_ctrl_q   ? host_ctrl_q     : '0;
  assign client_dout = client_sel_buf_q  ? client_ram_dout :
                       client_sel_ctrl_q ? client_ctrl_q   : '0;

endmodule

// File: tb/tb_frame_share_pingpong.sv
// tb/tb_frame_share_pingpong.sv - directed self-checking bench for frame_share_pingpong
module tb_frame_share_pingpong;

  logic        clk;
  logic        reset;
  logic        host_we;
  logic        host_sel_buf;
  logic        host_sel_ctrl;
  logic [31:0] host_addr;
  logic [31:0] host_din;
  logic [31:0] host_dout;
  logic        client_we;
  logic        client_sel_buf;
  logic        client_sel_ctrl;
  logic [31:0] client_addr;
  logic [31:0] client_din;
  logic [31:0] client_dout;
  logic        client_irq;
  logic        front;
  logic [15:0] drop_count;

  int checks = 0;
  int passes = 0;

  frame_share_pingpong #(.DATA_W(32), .ADDR_W(10), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .host_we         (host_we),
    .host_sel_buf    (host_sel_buf),
    .host_sel_ctrl   (host_sel_ctrl),
    .host_addr       (host_addr),
    .host_din        (host_din),
    .host_dout       (host_dout),
    .client_we       (client_we),
    .client_sel_buf  (client_sel_buf),
    .client_sel_ctrl (client_sel_ctrl),
    .client_addr     (client_addr),
    .client_din      (client_din),
    .client_dout     (client_dout),
    .client_irq      (client_irq),
    .front           (front),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    host_we = 0; host_sel_buf = 0; host_sel_ctrl = 0; host_addr = 0; host_din = 0;
    client_we = 0; client_sel_buf = 0; client_sel_ctrl = 0; client_addr = 0; client_din = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic host_ctrl_wr(input logic [31:0] d);
    host_we = 1; host_sel_ctrl = 1; host_din = d;
    tick; clr;
  endtask

  task automatic client_ctrl_wr(input logic [31:0] d);
    client_we = 1; client_sel_ctrl = 1; client_din = d;
    tick; clr;
  endtask

  task automatic host_ctrl_rd(input string tag, input logic [31:0] exp);
    host_sel_ctrl = 1;
    tick; clr;
    check(tag, host_dout, exp);
  endtask

  task automatic client_ctrl_rd(input string tag, input logic [31:0] exp);
    client_sel_ctrl = 1;
    tick; clr;
    check(tag, client_dout, exp);
  endtask

  initial begin
    clr;
    reset = 0;
    repeat (3) tick;
    reset = 1;

    // reset state
    check("rst_front", {31'b0, front}, 32'h0);
    check("rst_irq", {31'b0, client_irq}, 32'h0);
    check("rst_drop", {16'b0, drop_count}, 32'h0);
    check("rst_host_dout", host_dout, 32'h0);
    check("rst_client_dout", client_dout, 32'h0);
    host_ctrl_rd("rst_host_ctrl", 32'h0000_0000);
    client_ctrl_rd("rst_client_ctrl", 32'h0000_0004);

    // fill word 5 of back bank (bank 1), commit, swap follows one cycle later
    host_we = 1; host_sel_buf = 1; host_addr = 32'h14; host_din = 32'hA5A5_0001;
    tick; clr;
    host_ctrl_wr(32'h1);
    check("commit_front_before_swap", {31'b0, front}, 32'h0);
    tick;
    check("swap1_front", {31'b0, front}, 32'h1);
    check("swap1_irq", {31'b0, client_irq}, 32'h1);

    // client reads the new front bank with one cycle of latency
    client_sel_buf = 1; client_addr = 32'h14;
    check("client_rd_latency", client_dout, 32'h0);
    tick; clr;
    check("client_rd_word5", client_dout, 32'hA5A5_0001);
    client_ctrl_rd("client_ctrl_frame1", 32'h0001_0003);

    // ack, then commits without release: pending, then a drop
    client_ctrl_wr(32'h2);
    check("ack_irq", {31'b0, client_irq}, 32'h0);
    host_ctrl_wr(32'h1);
    host_ctrl_rd("host_ctrl_pending", 32'h0000_0003);
    check("no_swap_front", {31'b0, front}, 32'h1);
    host_ctrl_wr(32'h1);
    check("drop1", {16'b0, drop_count}, 32'h1);
    host_ctrl_rd("host_ctrl_drop1", 32'h0001_0003);

    // release with pending set swaps on the next cycle
    client_ctrl_wr(32'h1);
    check("release_front_hold", {31'b0, front}, 32'h1);
    tick;
    check("swap2_front", {31'b0, front}, 32'h0);
    check("swap2_irq", {31'b0, client_irq}, 32'h1);
    client_ctrl_rd("client_ctrl_frame2", 32'h0002_0002);
    host_ctrl_rd("host_ctrl_after_swap2", 32'h0001_0000);
    host_ctrl_wr(32'h2);
    host_ctrl_rd("host_ctrl_din0_clear", 32'h0001_0000);

    // release and commit together, then commit on the swap cycle
    host_we = 1; host_sel_ctrl = 1; host_din = 32'h1;
    client_we = 1; client_sel_ctrl = 1; client_din = 32'h1;
    tick; clr;
    check("rel_commit_no_swap_yet", {31'b0, front}, 32'h0);
    host_ctrl_wr(32'h1);
    check("swap3_front", {31'b0, front}, 32'h1);
    check("swap3_no_drop", {16'b0, drop_count}, 32'h1);
    host_ctrl_rd("host_ctrl_commit_on_swap", 32'h0001_0003);
    client_ctrl_rd("client_ctrl_frame3", 32'h0003_0003);

    // release plus ack on the swap cycle: idle stays set, irq stays set
    client_ctrl_wr(32'h2);
    check("ack2_irq", {31'b0, client_irq}, 32'h0);
    client_ctrl_wr(32'h1);
    client_ctrl_wr(32'h3);
    check("swap4_irq_priority", {31'b0, client_irq}, 32'h1);
    client_ctrl_rd("client_ctrl_release_on_swap", 32'h0004_0006);
    host_ctrl_wr(32'h1);
    tick;
    check("swap5_front", {31'b0, front}, 32'h1);
    client_ctrl_rd("client_ctrl_frame5", 32'h0005_0003);

    // reset mid-frame with pending=1, front=1
    host_ctrl_wr(32'h1);
    host_ctrl_rd("host_ctrl_pre_reset", 32'h0001_0003);
    reset = 0;
    tick;
    reset = 1;
    check("mid_rst_front", {31'b0, front}, 32'h0);
    check("mid_rst_irq", {31'b0, client_irq}, 32'h0);
    check("mid_rst_drop", {16'b0, drop_count}, 32'h0);
    check("mid_rst_host_dout", host_dout, 32'h0);
    host_ctrl_rd("mid_rst_host_ctrl", 32'h0000_0000);
    client_ctrl_rd("mid_rst_client_ctrl", 32'h0000_0004);
    host_sel_buf = 1; host_addr = 32'h14;
    tick; clr;
    check("stale_word5", host_dout, 32'hA5A5_0001);
    tick;
    check("no_sel_dout", host_dout, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_share_pingpong.md
Name: frame_share_pingpong

Overview:
Parametrised successor to the single-bank host/client shared memory between the physics beta (host) and the laser beta (client).
- Provides two banks of DATA_W x 2^ADDR_W words in ping-pong arrangement.
- Host fills the back bank; client reads the front bank.
- A commit/release handshake swaps the banks atomically.
- Client receives an irq on every new frame; a dropped-frame counter exposes overrun.

Parameters:
DATA_W, 32, data width of both ports
ADDR_W, 10, word address bits per bank; word address is taken from addr[ADDR_W+1:2]
CNT_W, 16, width of frame_count and drop_count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
host_we  in  1  host write strobe (mwe)
host_sel_buf  in  1  host access targets back bank
host_sel_ctrl  in  1  host access targets control register
host_addr  in  32  host byte address (ma)
host_din  in  DATA_W  host write data
host_dout  out  DATA_W  host read data, registered
client_we  in  1  client write strobe
client_sel_buf  in  1  client access targets front bank
client_sel_ctrl  in  1  client access targets control register
client_addr  in  32  client byte address
client_din  in  DATA_W  client write data
client_dout  out  DATA_W  client read data, registered
client_irq  out  1  new-frame interrupt, level
front  out  1  index of bank currently owned by client
drop_count  out  CNT_W  host commits that overwrote an uncollected frame

Behaviour:
- Reset (reset==0 at posedge), all values:
  - front=0, pending=0, client_idle=1, client_irq=0
  - frame_count=0, drop_count=0
  - host_dout=0, client_dout=0
  - RAM contents are not cleared.
- Bank mapping:
  - Host buffer accesses go to bank ~front.
  - Client buffer accesses go to bank front.
  - Physical RAM address is {bank, word_addr}.
- Reads:
  - 1-cycle latency; dout is valid the cycle after the address is presented, matching the BRAM timing of the read mux.
  - Ctrl reads also return registered data.
  - When neither sel is asserted, dout=0.
- Buffer writes: host_we&&host_sel_buf writes the back bank; client_we&&client_sel_buf writes the front bank (scratch use).
- Host ctrl (single register, address bits ignored):
  - Write with din[0]=1 is COMMIT; din[0]=0 has no effect.
  - Read returns {drop_count, 14'b0, pending, front}, zero-extended to DATA_W.
- Client ctrl:
  - Write with din[0]=1 is RELEASE (sets client_idle=1).
  - Write with din[1]=1 is IRQ_ACK (clears client_irq).
  - Read returns {frame_count, 13'b0, client_idle, client_irq, front}.
- COMMIT handling:
  - If pending=0: pending<=1.
  - If pending=1 and no swap occurs this cycle: drop_count<=drop_count+1, which saturates at all-ones.
- Swap: evaluated on registered flags. When pending&&client_idle, in one cycle:
  - front<=~front
  - pending<=0
  - client_idle<=0
  - client_irq<=1
  - frame_count<=frame_count+1 (wraps)
- Simultaneous events:
  - COMMIT in the same cycle as a swap: swap consumes the old frame, and pending is set again next cycle. No drop is counted.
  - RELEASE in the same cycle as a swap: client_idle ends at 1, because RELEASE has priority over the swap clear.
  - IRQ_ACK in the same cycle as a swap: client_irq ends at 1, because the swap has priority.
  - RELEASE and COMMIT in the same cycle from the idle-0/pending-0 state: both flags set; swap happens the following cycle.
- Access to a bank during the swap cycle uses the pre-swap front for that cycle's address decode.
- Reset mid-frame: handshake state returns to the reset values above. The host must re-commit; stale RAM data remains.
- No backpressure exists: all accesses complete in one cycle.

Decomposition:
- Shared package frame_share_pkg holds:
  - ctrl bit positions: COMMIT_BIT=0, RELEASE_BIT=0, IRQ_ACK_BIT=1
  - status field positions
  - the saturation helper constant.
- One natural sub-module: frame_share_dpram, a true dual-port RAM with parameters DATA_W and ADDR_W+1.
  - Each port has its own we, addr, din and registered dout.
  - Inferable as block RAM.

Test Plan:
- Reset -> front=0, client_irq=0, drop_count=0; host ctrl read returns 0x0; client ctrl read returns 0x4 (client_idle=1).
- Host writes 0xA5A5_0001 at word 5 of the back bank, then COMMIT -> one cycle later front=1, client_irq=1; client reads word 5 and gets 0xA5A5_0001 with 1-cycle latency; frame_count=1.
- Client IRQ_ACK (din=0x2) -> client_irq=0; host COMMIT without client RELEASE -> pending=1, front unchanged; second COMMIT -> drop_count=1.
- Client RELEASE (din=0x1) with pending=1 -> next cycle front toggles, irq=1, pending=0, frame_count=2.
- COMMIT issued in the same cycle as a swap -> pending=1 afterwards, drop_count unchanged; RELEASE in the same cycle as a swap -> client_idle=1, so the next COMMIT swaps immediately.
- Assert reset mid-frame with pending=1, front=1 -> all handshake state at reset values next cycle; word 5 data still readable by host in bank 1 (now back bank).
